// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Pattern-driven note source feeding the square-wave oscillator. Plays a
// 16-entry writable note pattern at a programmable tempo, converts each note
// code into the oscillator's counter_top period (12 MHz clock assumed) and
// drives a gate that mutes or passes the tone downstream.
//
// Build option: define NOTE_SEQ_LOOP_EN to make the pattern wrap to step 0
// forever. Without it the sequencer stops in DONE after step seq_len_i and
// pulses done_o once.
//
// Ports
//   clk_i          system clock
//   rst_ni         synchronous reset, active low
//   run_i          level: 1 = play, 0 = stop and return to step 0
//   step_ticks_i   clocks per step (0 behaves as 1)
//   gate_ticks_i   clocks the gate stays high per sounding step
//   seq_len_i      last step index (pattern plays seq_len_i+1 steps)
//   wr_en_i        pattern write strobe
//   wr_addr_i      pattern write address
//   wr_note_i      note code: [7] sound, [6:4] octave, [3:0] semitone
//   counter_top_o  oscillator period
//   gate_o         note sounding
//   step_idx_o     index of the current step
//   step_pulse_o   one-cycle strobe on each step load
//   done_o         one-cycle strobe at pattern end (tied 0 in loop build)
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int WIDTH  = 18,
    parameter int TICK_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [TICK_W-1:0] step_ticks_i,
    input  logic [TICK_W-1:0] gate_ticks_i,
    input  logic [3:0]        seq_len_i,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [7:0]        wr_note_i,
    output logic [WIDTH-1:0]  counter_top_o,
    output logic              gate_o,
    output logic [3:0]        step_idx_o,
    output logic              step_pulse_o,
    output logic              done_o
);

    // state | meaning
    // IDLE  | stopped, step 0 selected, gate low; waits for run_i
    // PLAY  | stepping through the pattern
    // DONE  | pattern finished (non-loop build); holds until run_i drops
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [TICK_W-1:0] tick_q;
    logic [7:0]        pattern_q [16];
    logic [WIDTH-1:0]  counter_top_q;
    logic              gate_q;
    logic [3:0]        step_idx_q;
    logic              step_pulse_q;
`ifndef NOTE_SEQ_LOOP_EN
    logic              done_q;
`endif

    // -------------------------------------------------------------------------
    // Period lookup: C2..B2 base periods shifted down by the octave.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] note_period(input logic [7:0] note);
        logic [16:0]      base;
        logic [WIDTH-1:0] period;
        case (note[3:0])
            4'd0:    base = 17'd91732;
            4'd1:    base = 17'd86585;
            4'd2:    base = 17'd81725;
            4'd3:    base = 17'd77138;
            4'd4:    base = 17'd72809;
            4'd5:    base = 17'd68721;
            4'd6:    base = 17'd64865;
            4'd7:    base = 17'd61224;
            4'd8:    base = 17'd57788;
            4'd9:    base = 17'd54544;
            4'd10:   base = 17'd51483;
            4'd11:   base = 17'd48593;
            default: base = 17'd0;
        endcase
        period       = '0;
        period[16:0] = base >> note[6:4];
        return period;
    endfunction

    // -------------------------------------------------------------------------
    // Pattern storage. Reads are combinational from the flops, so a write on
    // the same edge as a load of that address only affects later visits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                pattern_q[i] <= 8'h00;
            end
        end else if (wr_en_i) begin
            pattern_q[wr_addr_i] <= wr_note_i;
        end
    end

    // -------------------------------------------------------------------------
    // Step timing and next-step selection
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] eff_ticks_d;
    logic [TICK_W-1:0] eff_last_d;
    logic [TICK_W:0]   tick_inc_d;
    logic              step_end_d;
    logic              gate_fall_d;
    logic              wrap_d;
    logic [3:0]        load_idx_d;
    logic [7:0]        load_note_d;
    logic              load_sound_d;
    logic [WIDTH-1:0]  load_period_d;
    logic              load_now_d;

    always_comb begin
        eff_ticks_d = (step_ticks_i == '0) ? TICK_W'(1) : step_ticks_i;
        eff_last_d  = eff_ticks_d - TICK_W'(1);
        tick_inc_d  = {1'b0, tick_q} + {{TICK_W{1'b0}}, 1'b1};
        // >= rather than == so a tempo shortened below the current tick
        // ends the step at once instead of waiting for the counter to wrap.
        step_end_d  = (tick_q >= eff_last_d);
        gate_fall_d = (gate_ticks_i < eff_ticks_d) &&
                      (tick_inc_d == {1'b0, gate_ticks_i});
        wrap_d      = (step_idx_q >= seq_len_i);

        if (state_q == IDLE) begin
            load_idx_d = 4'd0;
        end else if (wrap_d) begin
            load_idx_d = 4'd0;
        end else begin
            load_idx_d = step_idx_q + 4'd1;
        end

        load_note_d   = pattern_q[load_idx_d];
        load_sound_d  = load_note_d[7] && (load_note_d[3:0] <= 4'd11);
        load_period_d = note_period(load_note_d);

        load_now_d = 1'b0;
        if (state_q == IDLE && run_i) begin
            load_now_d = 1'b1;
        end else if (state_q == PLAY && run_i && step_end_d) begin
`ifdef NOTE_SEQ_LOOP_EN
            load_now_d = 1'b1;
`else
            load_now_d = !wrap_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            counter_top_q <= '0;
            gate_q        <= 1'b0;
            step_idx_q    <= 4'd0;
            step_pulse_q  <= 1'b0;
`ifndef NOTE_SEQ_LOOP_EN
            done_q        <= 1'b0;
`endif
        end else begin
            step_pulse_q <= 1'b0;
`ifndef NOTE_SEQ_LOOP_EN
            done_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    gate_q     <= 1'b0;
                    tick_q     <= '0;
                    step_idx_q <= 4'd0;
                    if (run_i) begin
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (!run_i) begin
                        state_q    <= IDLE;
                        gate_q     <= 1'b0;
                        tick_q     <= '0;
                        step_idx_q <= 4'd0;
                    end else if (step_end_d) begin
`ifndef NOTE_SEQ_LOOP_EN
                        if (wrap_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            gate_q  <= 1'b0;
                        end
`endif
                    end else begin
                        tick_q <= tick_inc_d[TICK_W-1:0];
                        if (gate_fall_d) begin
                            gate_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    gate_q <= 1'b0;
                    if (!run_i) begin
                        state_q    <= IDLE;
                        tick_q     <= '0;
                        step_idx_q <= 4'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Step load overrides the per-state updates above.
            if (load_now_d) begin
                step_idx_q   <= load_idx_d;
                gate_q       <= load_sound_d && (gate_ticks_i != '0);
                step_pulse_q <= 1'b1;
                tick_q       <= '0;
                if (load_sound_d) begin
                    counter_top_q <= load_period_d;
                end
            end
        end
    end

    assign counter_top_o = counter_top_q;
    assign gate_o        = gate_q;
    assign step_idx_o    = step_idx_q;
    assign step_pulse_o  = step_pulse_q;
`ifdef NOTE_SEQ_LOOP_EN
    assign done_o        = 1'b0;
`else
    assign done_o        = done_q;
`endif

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Pattern-driven note source that sits directly upstream of the square-wave oscillator. It steps through a 16-entry writable pattern at a programmable tempo and converts each note code to the oscillator's `counter_top` period. It also drives a `gate` that downstream logic uses to mute or pass the tone. The period table assumes a 12 MHz `clk`: the oscillator toggles every `counter_top+1` cycles, so the output frequency is 12e6 / (2·(`counter_top`+1)).

## Interface
- `WIDTH`, 18: `counter_top` width; must be ≥17.
- `TICK_W`, 24: width of the tempo and gate-length inputs.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-low.
- `run`  in  1: level; high = play, low = stop.
- `step_ticks`  in  TICK_W: clocks per step; 0 is treated as 1.
- `gate_ticks`  in  TICK_W: clocks `gate` stays high per sounding step; any value ≥ `step_ticks` gives legato.
- `seq_len`  in  4: last step index; the pattern plays `seq_len`+1 steps.
- `wr_en`  in  1: pattern write strobe.
- `wr_addr`  in  4: pattern write address.
- `wr_note`  in  8: note code. Bit [7] = sound, [6:4] = octave, [3:0] = semitone.
- `counter_top`  out  WIDTH: period to the oscillator.
- `gate`  out  1: note sounding.
- `step_idx`  out  4: index of the current step.
- `step_pulse`  out  1: one-cycle strobe on each step load.
- `done`  out  1: one-cycle strobe at pattern end (non-loop build only).

## Operation
- Pattern storage: 16×8 flop array, read combinationally, written on `wr_en`. Writes are allowed at any time.
  - A write to the address being loaded on the same edge does not affect that load: the old value is used and the new value takes effect on the next visit.
- Note decode: a note sounds only if bit7=1 and semitone ≤11. Otherwise it is a rest.
- Period for a sounding note: `counter_top` = BASE[semitone] >> octave, zero-extended to WIDTH.
- BASE table, C2..B2: 91732, 86585, 81725, 77138, 72809, 68721, 64865, 61224, 57788, 54544, 51483, 48593.
- Rest: `gate`=0 for the whole step; `counter_top` holds its previous value.
- States: IDLE, PLAY, DONE.
  - IDLE: `gate`=0, tick=0, `step_idx`=0. If `run`=1, load step 0 and go to PLAY.
  - PLAY: tick increments each cycle.
    - When tick = eff_ticks−1 (eff_ticks = max(`step_ticks`,1)), advance to the next step.
    - Next index: `step_idx`+1, or 0 if `step_idx` ≥ `seq_len`. This comparison happens at each advance, so changes to `seq_len` apply mid-run.
  - `run`=0 in PLAY or DONE: on the next edge go to IDLE, `gate`=0, tick=0, `step_idx`=0.
  - DONE: `gate`=0 and outputs hold. Leaves only when `run`=0.
- Load action, on one edge: `step_idx`, `counter_top` (if sounding), `gate` = sounding && `gate_ticks`≠0, `step_pulse`=1, tick=0.
- Gate fall: `gate` clears on the edge where tick becomes `gate_ticks`, provided `gate_ticks` < eff_ticks. A sounding step therefore gates for exactly `gate_ticks` cycles.

## Timing
- Reset values: `counter_top`=0, `gate`=0, `step_idx`=0, `step_pulse`=0, `done`=0. State is IDLE, tick=0, and all pattern entries are 0 (rest).
- All outputs are registered.
- `run` sampled high in IDLE at edge N: step 0 loads at edge N, and `step_pulse` is high in cycle N+1.
- Step period is exactly eff_ticks cycles; `step_pulse` spacing equals eff_ticks.
- Changes to `step_ticks` and `gate_ticks` take effect on the next tick comparison; there is no restart.
- Reset asserted mid-step overrides everything on that edge.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined: after step `seq_len` the sequence wraps to step 0 indefinitely. DONE is unreachable and `done` is tied to 0.
- Not defined: after step `seq_len` expires, go to DONE instead of loading.
  - That edge sets `done`=1 for one cycle and `gate`=0.
  - Replay requires `run` low, then high.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `run`=1 → all outputs 0 and no `step_pulse`.
- Decode: write addr0=0x80 (C, oct 0), addr1=0x99 (A, oct 1), addr2=0x0C (rest); `seq_len`=2, `step_ticks`=10, `gate_ticks`=6, `run`=1.
  - → `counter_top` = 91732, then 27272, then held at 27272.
  - → `gate` high for 6 of each 10 cycles on steps 0–1 and low for all of step 2.
  - → `step_pulse` every 10 cycles.
- Loop vs stop, same pattern:
  - `NOTE_SEQ_LOOP_EN` defined → `step_idx` runs 0,1,2,0,1.
  - Not defined → `done` pulses 30 cycles after start and `step_idx` holds 2. `run` 0→1 restarts at step 0.
- Edge cases:
  - `step_ticks`=0 → a step on every cycle.
  - `gate_ticks`=20 with `step_ticks`=10 → `gate` stays continuously high across consecutive sounding steps.
- Write collision: write addr1=0x84 on the same edge that step 1 loads → that pass still uses 0x99; the next loop uses 72809.
- Stop mid-step: drop `run` during tick 4 of step 1 → next edge `gate`=0 and `step_idx`=0.
  - Raising `run` again → step 0 reloads with `step_pulse`.
